// File: rtl/reg_writeback_pkg.sv
// Shared types and sizes for the lane write-back stage and its slice registers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the result width, register-file slice width, physical tag width and
// active-list index width, plus the write-back, bypass and completion packet
// typedefs used inside reg_writeback.
package reg_writeback_pkg;

    localparam int SIZE_DATA           = 32;
    localparam int SRAM_DATA_WIDTH     = 8;
    localparam int SIZE_PHYSICAL_LOG   = 7;
    localparam int SIZE_ACTIVELIST_LOG = 7;
    localparam int NUM_SLICES          = SIZE_DATA / SRAM_DATA_WIDTH;

    // Completed result as handed over by the functional unit.
    typedef struct packed {
        logic                           valid;
        logic [SIZE_PHYSICAL_LOG-1:0]   phy_dest;
        logic [SIZE_DATA-1:0]           data;
        logic [SIZE_ACTIVELIST_LOG-1:0] al_id;
        logic                           exception;
    } wb_pkt_t;

    // Full-width value broadcast to the bypass network.
    typedef struct packed {
        logic                         valid;
        logic [SIZE_PHYSICAL_LOG-1:0] tag;
        logic [SIZE_DATA-1:0]         data;
    } bypass_pkt_t;

    // Completion notice to the active list.
    typedef struct packed {
        logic                           valid;
        logic [SIZE_ACTIVELIST_LOG-1:0] al_id;
        logic                           exception;
    } ctrl_pkt_t;

endpackage

// File: rtl/reg_writeback_wb_slice_stage.sv
// One write-back pipeline register: valid, tag, the bytes still to be written, alID, exception.
// Latency: 1 cycle.
// Backpressure: none; loads every clock, valid cleared by reset or flush.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset (clears everything)
//   flush             squash: the stage loads as invalid at this edge
//   src_*             previous stage (or the lane input for stage 0)
//   stage_*           registered copy; stage_data[SRAM_DATA_WIDTH-1:0] is the
//                     byte this stage writes, upper bytes feed the next stage
module wb_slice_stage #(
    parameter int NUM_BYTES           = reg_writeback_pkg::NUM_SLICES,
    parameter int SRAM_DATA_WIDTH     = reg_writeback_pkg::SRAM_DATA_WIDTH,
    parameter int SIZE_PHYSICAL_LOG   = reg_writeback_pkg::SIZE_PHYSICAL_LOG,
    parameter int SIZE_ACTIVELIST_LOG = reg_writeback_pkg::SIZE_ACTIVELIST_LOG
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 flush,
    input  logic                                 src_valid,
    input  logic [SIZE_PHYSICAL_LOG-1:0]         src_tag,
    input  logic [NUM_BYTES*SRAM_DATA_WIDTH-1:0] src_data,
    input  logic [SIZE_ACTIVELIST_LOG-1:0]       src_al_id,
    input  logic                                 src_exception,
    output logic                                 stage_valid,
    output logic [SIZE_PHYSICAL_LOG-1:0]         stage_tag,
    output logic [NUM_BYTES*SRAM_DATA_WIDTH-1:0] stage_data,
    output logic [SIZE_ACTIVELIST_LOG-1:0]       stage_al_id,
    output logic                                 stage_exception
);

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid     <= 1'b0;
            stage_tag       <= '0;
            stage_data      <= '0;
            stage_al_id     <= '0;
            stage_exception <= 1'b0;
        end else begin
            // Only the valid bit matters for a squash; the payload is
            // don't-care once valid is low, so it keeps loading.
            stage_valid     <= src_valid & ~flush;
            stage_tag       <= src_tag;
            stage_data      <= src_data;
            stage_al_id     <= src_al_id;
            stage_exception <= src_exception;
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Lane write-back: writes a completed result into the byte-sliced register file, drives bypass and completion.
// Latency: byte0/bypass T+1; with WB_BYTE_STAGGER_EN byte k at T+1+k and completion at T+4, else all at T+1.
// Backpressure: none; one result accepted every cycle, reset/recoverFlag_i squash everything in flight.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   recoverFlag_i               squash all in-flight writes (input that cycle dropped)
//   wb*_i                       result from the functional unit
//   wrEn/wrAddr/wrData_byteN_o  register-file slice N write port
//   bypass*_o                   full-width bypass packet (from the first stage)
//   ctrl*_o                     completion to the active list (stage writing byte 3)
//   inflight_o                  number of valid stage registers
// Build option: WB_BYTE_STAGGER_EN selects the four-stage staggered pipeline;
// it has to agree with the read-side slice depth.
module reg_writeback #(
    parameter int SIZE_DATA           = reg_writeback_pkg::SIZE_DATA,
    parameter int SRAM_DATA_WIDTH     = reg_writeback_pkg::SRAM_DATA_WIDTH,
    parameter int SIZE_PHYSICAL_LOG   = reg_writeback_pkg::SIZE_PHYSICAL_LOG,
    parameter int SIZE_ACTIVELIST_LOG = reg_writeback_pkg::SIZE_ACTIVELIST_LOG
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           recoverFlag_i,
    input  logic                           wbValid_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]   wbPhyDest_i,
    input  logic [SIZE_DATA-1:0]           wbData_i,
    input  logic [SIZE_ACTIVELIST_LOG-1:0] wbAlID_i,
    input  logic                           wbException_i,
    output logic                           wrEn_byte0_o,
    output logic                           wrEn_byte1_o,
    output logic                           wrEn_byte2_o,
    output logic                           wrEn_byte3_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]   wrAddr_byte0_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]   wrAddr_byte1_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]   wrAddr_byte2_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]   wrAddr_byte3_o,
    output logic [SRAM_DATA_WIDTH-1:0]     wrData_byte0_o,
    output logic [SRAM_DATA_WIDTH-1:0]     wrData_byte1_o,
    output logic [SRAM_DATA_WIDTH-1:0]     wrData_byte2_o,
    output logic [SRAM_DATA_WIDTH-1:0]     wrData_byte3_o,
    output logic                           bypassValid_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]   bypassTag_o,
    output logic [SIZE_DATA-1:0]           bypassData_o,
    output logic                           ctrlValid_o,
    output logic [SIZE_ACTIVELIST_LOG-1:0] ctrlAlID_o,
    output logic                           ctrlException_o,
    output logic [2:0]                     inflight_o
);

    import reg_writeback_pkg::*;

    localparam int W = SRAM_DATA_WIDTH;

    wb_pkt_t     wb_in;
    bypass_pkt_t bypass_pkt;
    ctrl_pkt_t   ctrl_pkt;

    always_comb begin
        wb_in           = '0;
        wb_in.valid     = wbValid_i;
        wb_in.phy_dest  = wbPhyDest_i;
        wb_in.data      = wbData_i;
        wb_in.al_id     = wbAlID_i;
        wb_in.exception = wbException_i;
    end

`ifdef WB_BYTE_STAGGER_EN
    // Stage k holds bytes k..3 of its result at the low end of its data
    // register; the low byte is written by stage k and the rest moves on.
    logic                           s0_valid, s1_valid, s2_valid, s3_valid;
    logic [SIZE_PHYSICAL_LOG-1:0]   s0_tag, s1_tag, s2_tag, s3_tag;
    logic [4*W-1:0]                 s0_data;
    logic [3*W-1:0]                 s1_data;
    logic [2*W-1:0]                 s2_data;
    logic [W-1:0]                   s3_data;
    logic [SIZE_ACTIVELIST_LOG-1:0] s0_al_id, s1_al_id, s2_al_id, s3_al_id;
    logic                           s0_exc, s1_exc, s2_exc, s3_exc;

    wb_slice_stage #(
        .NUM_BYTES(4), .SRAM_DATA_WIDTH(W),
        .SIZE_PHYSICAL_LOG(SIZE_PHYSICAL_LOG), .SIZE_ACTIVELIST_LOG(SIZE_ACTIVELIST_LOG)
    ) u_stage0 (
        .clk(clk), .reset(reset), .flush(recoverFlag_i),
        .src_valid(wb_in.valid), .src_tag(wb_in.phy_dest), .src_data(wb_in.data),
        .src_al_id(wb_in.al_id), .src_exception(wb_in.exception),
        .stage_valid(s0_valid), .stage_tag(s0_tag), .stage_data(s0_data),
        .stage_al_id(s0_al_id), .stage_exception(s0_exc)
    );

    wb_slice_stage #(
        .NUM_BYTES(3), .SRAM_DATA_WIDTH(W),
        .SIZE_PHYSICAL_LOG(SIZE_PHYSICAL_LOG), .SIZE_ACTIVELIST_LOG(SIZE_ACTIVELIST_LOG)
    ) u_stage1 (
        .clk(clk), .reset(reset), .flush(recoverFlag_i),
        .src_valid(s0_valid), .src_tag(s0_tag), .src_data(s0_data[4*W-1:W]),
        .src_al_id(s0_al_id), .src_exception(s0_exc),
        .stage_valid(s1_valid), .stage_tag(s1_tag), .stage_data(s1_data),
        .stage_al_id(s1_al_id), .stage_exception(s1_exc)
    );

    wb_slice_stage #(
        .NUM_BYTES(2), .SRAM_DATA_WIDTH(W),
        .SIZE_PHYSICAL_LOG(SIZE_PHYSICAL_LOG), .SIZE_ACTIVELIST_LOG(SIZE_ACTIVELIST_LOG)
    ) u_stage2 (
        .clk(clk), .reset(reset), .flush(recoverFlag_i),
        .src_valid(s1_valid), .src_tag(s1_tag), .src_data(s1_data[3*W-1:W]),
        .src_al_id(s1_al_id), .src_exception(s1_exc),
        .stage_valid(s2_valid), .stage_tag(s2_tag), .stage_data(s2_data),
        .stage_al_id(s2_al_id), .stage_exception(s2_exc)
    );

    wb_slice_stage #(
        .NUM_BYTES(1), .SRAM_DATA_WIDTH(W),
        .SIZE_PHYSICAL_LOG(SIZE_PHYSICAL_LOG), .SIZE_ACTIVELIST_LOG(SIZE_ACTIVELIST_LOG)
    ) u_stage3 (
        .clk(clk), .reset(reset), .flush(recoverFlag_i),
        .src_valid(s2_valid), .src_tag(s2_tag), .src_data(s2_data[2*W-1:W]),
        .src_al_id(s2_al_id), .src_exception(s2_exc),
        .stage_valid(s3_valid), .stage_tag(s3_tag), .stage_data(s3_data),
        .stage_al_id(s3_al_id), .stage_exception(s3_exc)
    );

    assign wrEn_byte0_o   = s0_valid;
    assign wrEn_byte1_o   = s1_valid;
    assign wrEn_byte2_o   = s2_valid;
    assign wrEn_byte3_o   = s3_valid;
    assign wrAddr_byte0_o = s0_tag;
    assign wrAddr_byte1_o = s1_tag;
    assign wrAddr_byte2_o = s2_tag;
    assign wrAddr_byte3_o = s3_tag;
    assign wrData_byte0_o = s0_data[W-1:0];
    assign wrData_byte1_o = s1_data[W-1:0];
    assign wrData_byte2_o = s2_data[W-1:0];
    assign wrData_byte3_o = s3_data;

    always_comb begin
        bypass_pkt           = '0;
        bypass_pkt.valid     = s0_valid;
        bypass_pkt.tag       = s0_tag;
        bypass_pkt.data      = s0_data;
        // Completion only once the last slice is being committed.
        ctrl_pkt             = '0;
        ctrl_pkt.valid       = s3_valid;
        ctrl_pkt.al_id       = s3_al_id;
        ctrl_pkt.exception   = s3_exc;
    end

    assign inflight_o = {2'b00, s0_valid} + {2'b00, s1_valid}
                      + {2'b00, s2_valid} + {2'b00, s3_valid};
`else
    // Single stage: every slice, the bypass and the completion all fire
    // together in the cycle after the result is captured.
    logic                           s0_valid;
    logic [SIZE_PHYSICAL_LOG-1:0]   s0_tag;
    logic [4*W-1:0]                 s0_data;
    logic [SIZE_ACTIVELIST_LOG-1:0] s0_al_id;
    logic                           s0_exc;

    wb_slice_stage #(
        .NUM_BYTES(4), .SRAM_DATA_WIDTH(W),
        .SIZE_PHYSICAL_LOG(SIZE_PHYSICAL_LOG), .SIZE_ACTIVELIST_LOG(SIZE_ACTIVELIST_LOG)
    ) u_stage0 (
        .clk(clk), .reset(reset), .flush(recoverFlag_i),
        .src_valid(wb_in.valid), .src_tag(wb_in.phy_dest), .src_data(wb_in.data),
        .src_al_id(wb_in.al_id), .src_exception(wb_in.exception),
        .stage_valid(s0_valid), .stage_tag(s0_tag), .stage_data(s0_data),
        .stage_al_id(s0_al_id), .stage_exception(s0_exc)
    );

    assign wrEn_byte0_o   = s0_valid;
    assign wrEn_byte1_o   = s0_valid;
    assign wrEn_byte2_o   = s0_valid;
    assign wrEn_byte3_o   = s0_valid;
    assign wrAddr_byte0_o = s0_tag;
    assign wrAddr_byte1_o = s0_tag;
    assign wrAddr_byte2_o = s0_tag;
    assign wrAddr_byte3_o = s0_tag;
    assign wrData_byte0_o = s0_data[W-1:0];
    assign wrData_byte1_o = s0_data[2*W-1:W];
    assign wrData_byte2_o = s0_data[3*W-1:2*W];
    assign wrData_byte3_o = s0_data[4*W-1:3*W];

    always_comb begin
        bypass_pkt           = '0;
        bypass_pkt.valid     = s0_valid;
        bypass_pkt.tag       = s0_tag;
        bypass_pkt.data      = s0_data;
        ctrl_pkt             = '0;
        ctrl_pkt.valid       = s0_valid;
        ctrl_pkt.al_id       = s0_al_id;
        ctrl_pkt.exception   = s0_exc;
    end

    assign inflight_o = {2'b00, s0_valid};
`endif

    assign bypassValid_o   = bypass_pkt.valid;
    assign bypassTag_o     = bypass_pkt.tag;
    assign bypassData_o    = bypass_pkt.data;
    assign ctrlValid_o     = ctrl_pkt.valid;
    assign ctrlAlID_o      = ctrl_pkt.al_id;
    assign ctrlException_o = ctrl_pkt.exception;

endmodule
